// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sweep sequencer: sequencer states,
// default widths and the DDS output-mode encodings.
package dds_pkg;

    localparam int FW_DEF  = 24;
    localparam int DWW_DEF = 16;

    localparam logic [1:0] MODE_CW    = 2'd0;
    localparam logic [1:0] MODE_AM    = 2'd1;
    localparam logic [1:0] MODE_FM    = 2'd2;
    localparam logic [1:0] MODE_DEMOD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DWELL = 2'd2,
        ST_FIN   = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/dds_dwell_timer.sv
// Dwell down-counter for the sweep sequencer. A load programs
// max(value,1)-1 so a dwell of 0 behaves like 1; zero flags the last
// cycle of the current frequency point.
module dds_dwell_timer #(
    parameter int DWW = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           dec,
    input  logic [DWW-1:0] value,
    output logic           zero
);

    logic [DWW-1:0] cnt_r;

    // Counter: reload takes priority, otherwise count down to zero and stop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {DWW{1'b0}};
        end else if (load) begin
            cnt_r <= (value == {DWW{1'b0}}) ? {DWW{1'b0}}
                                            : value - {{(DWW-1){1'b0}}, 1'b1};
        end else if (dec && (cnt_r != {DWW{1'b0}})) begin
            cnt_r <= cnt_r - {{(DWW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {DWW{1'b0}});

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency sweep sequencer for the DDS core. Takes a sweep config over
// valid/ready, then steps fc from f_start to f_stop holding each point for
// max(dwell,1) cycles. Optional build macro SWEEP_PINGPONG_EN turns the
// single upward pass into an endless up/down sweep ended only by abort.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int            FW     = FW_DEF,
    parameter int            DWW    = DWW_DEF,
    parameter logic [FW-1:0] RST_FC = 24'd100000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [FW-1:0]  cfg_f_start,
    input  logic [FW-1:0]  cfg_f_stop,
    input  logic [FW-1:0]  cfg_f_step,
    input  logic [DWW-1:0] cfg_dwell,
    input  logic [1:0]     cfg_mode,
    input  logic [FW-1:0]  cfg_fs,
    input  logic [3:0]     cfg_ma,
    input  logic [15:0]    cfg_fd,
    input  logic           start,
    input  logic           abort,
    output logic [FW-1:0]  fc,
    output logic [FW-1:0]  fs,
    output logic [3:0]     ma,
    output logic [15:0]    fd,
    output logic [1:0]     mode,
    output logic           busy,
    output logic           done,
    output logic           step_tick,
    output logic           cfg_err
);

    sweep_state_t   state_r, state_nx_s;
    logic [FW-1:0]  sh_f_start_r, sh_f_stop_r, sh_f_step_r, sh_fs_r;
    logic [DWW-1:0] sh_dwell_r;
    logic [1:0]     sh_mode_r, mode_r;
    logic [3:0]     sh_ma_r, ma_r;
    logic [15:0]    sh_fd_r, fd_r;
    logic           cfg_valid_q_r, cfg_err_r;
    logic [FW-1:0]  fc_r, fc_nx_s, fs_r;
    logic           busy_r, done_r, step_tick_r;
    logic           tmr_load_s, tmr_dec_s, tmr_zero_s, step_s, ld_s;
    logic           cfg_legal_s, cfg_take_s;
    logic [FW:0]    sum_s;
    logic [FW-1:0]  up_s;
`ifdef SWEEP_PINGPONG_EN
    logic           dir_r, dir_nx_s;
    logic [FW:0]    room_s;
    logic [FW-1:0]  dn_s;
`endif

    assign cfg_ready   = (state_r == ST_IDLE);
    assign cfg_take_s  = cfg_valid && cfg_ready;
    assign cfg_legal_s = (cfg_f_start <= cfg_f_stop) && (cfg_f_step != {FW{1'b0}});

    // One extra bit on the sum so stepping near full scale clamps instead of wrapping.
    assign sum_s = {1'b0, fc_r} + {1'b0, sh_f_step_r};
    assign up_s  = (sum_s > {1'b0, sh_f_stop_r}) ? sh_f_stop_r : sum_s[FW-1:0];
`ifdef SWEEP_PINGPONG_EN
    // fc never drops below f_start, so the distance above it decides the clamp.
    assign room_s = {1'b0, fc_r} - {1'b0, sh_f_start_r};
    assign dn_s   = (room_s > {1'b0, sh_f_step_r}) ? (fc_r - sh_f_step_r) : sh_f_start_r;
`endif

    dds_dwell_timer #(.DWW(DWW)) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load_s),
        .dec   (tmr_dec_s),
        .value (sh_dwell_r),
        .zero  (tmr_zero_s)
    );

    // Sequencer next-state, next fc and timer control.
    always_comb begin
        state_nx_s = state_r;
        fc_nx_s    = fc_r;
        tmr_load_s = 1'b0;
        tmr_dec_s  = 1'b0;
        step_s     = 1'b0;
        ld_s       = 1'b0;
`ifdef SWEEP_PINGPONG_EN
        dir_nx_s   = dir_r;
`endif
        if (abort) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && cfg_valid_q_r) begin
                        state_nx_s = ST_LOAD;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    ld_s       = 1'b1;
                    fc_nx_s    = sh_f_start_r;
                    tmr_load_s = 1'b1;
                    state_nx_s = ST_DWELL;
`ifdef SWEEP_PINGPONG_EN
                    dir_nx_s   = 1'b0;
`endif
                end
                ST_DWELL: begin
                    if (!tmr_zero_s) begin
                        tmr_dec_s = 1'b1;
                    end else begin
`ifdef SWEEP_PINGPONG_EN
                        tmr_load_s = 1'b1;
                        if (!dir_r) begin
                            if (fc_r == sh_f_stop_r) begin
                                dir_nx_s = 1'b1;
                                fc_nx_s  = dn_s;
                            end else begin
                                fc_nx_s  = up_s;
                            end
                        end else begin
                            if (fc_r == sh_f_start_r) begin
                                dir_nx_s = 1'b0;
                                fc_nx_s  = up_s;
                            end else begin
                                fc_nx_s  = dn_s;
                            end
                        end
                        step_s = (fc_nx_s != fc_r);
`else
                        if (fc_r == sh_f_stop_r) begin
                            state_nx_s = ST_FIN;
                        end else begin
                            fc_nx_s    = up_s;
                            step_s     = 1'b1;
                            tmr_load_s = 1'b1;
                        end
`endif
                    end
                end
                ST_FIN: begin
                    state_nx_s = ST_IDLE;
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, DDS control outputs and status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            fc_r        <= RST_FC;
            fs_r        <= {FW{1'b0}};
            ma_r        <= 4'd0;
            fd_r        <= 16'd0;
            mode_r      <= MODE_CW;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            step_tick_r <= 1'b0;
`ifdef SWEEP_PINGPONG_EN
            dir_r       <= 1'b0;
`endif
        end else begin
            state_r     <= state_nx_s;
            fc_r        <= fc_nx_s;
            busy_r      <= (state_nx_s == ST_LOAD) || (state_nx_s == ST_DWELL);
            done_r      <= (state_nx_s == ST_FIN);
            step_tick_r <= step_s;
`ifdef SWEEP_PINGPONG_EN
            dir_r       <= dir_nx_s;
`endif
            if (ld_s) begin
                fs_r   <= sh_fs_r;
                ma_r   <= sh_ma_r;
                fd_r   <= sh_fd_r;
                mode_r <= sh_mode_r;
            end else begin
                fs_r   <= fs_r;
                ma_r   <= ma_r;
                fd_r   <= fd_r;
                mode_r <= mode_r;
            end
        end
    end

    // Config shadow capture and legality flag, only while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_f_start_r  <= {FW{1'b0}};
            sh_f_stop_r   <= {FW{1'b0}};
            sh_f_step_r   <= {FW{1'b0}};
            sh_dwell_r    <= {DWW{1'b0}};
            sh_mode_r     <= MODE_CW;
            sh_fs_r       <= {FW{1'b0}};
            sh_ma_r       <= 4'd0;
            sh_fd_r       <= 16'd0;
            cfg_valid_q_r <= 1'b0;
            cfg_err_r     <= 1'b0;
        end else if (cfg_take_s) begin
            sh_f_start_r  <= cfg_f_start;
            sh_f_stop_r   <= cfg_f_stop;
            sh_f_step_r   <= cfg_f_step;
            sh_dwell_r    <= cfg_dwell;
            sh_mode_r     <= cfg_mode;
            sh_fs_r       <= cfg_fs;
            sh_ma_r       <= cfg_ma;
            sh_fd_r       <= cfg_fd;
            cfg_valid_q_r <= cfg_legal_s;
            cfg_err_r     <= !cfg_legal_s;
        end else begin
            cfg_err_r     <= 1'b0;
        end
    end

    assign fc        = fc_r;
    assign fs        = fs_r;
    assign ma        = ma_r;
    assign fd        = fd_r;
    assign mode      = mode_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign step_tick = step_tick_r;
    assign cfg_err   = cfg_err_r;

endmodule
